// File: rtl/scope_pkg.sv
// Shared widths, screen geometry and colour constants for the scope trace renderer.
package scope_pkg;

  localparam int unsigned DATA_W    = 14;
  localparam int unsigned COORD_W   = 11;
  localparam int unsigned H_ACTIVE  = 800;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned Y_SHIFT   = 5;
  localparam int unsigned GRID_STEP = 50;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t TRACE_RGB = '{r: 8'd0,  g: 8'd255, b: 8'd0};
  localparam rgb_t GRID_RGB  = '{r: 8'd64, g: 8'd64,  b: 8'd64};
  localparam rgb_t BG_RGB    = '{r: 8'd0,  g: 8'd0,   b: 8'd0};

endpackage

// File: rtl/scope_row_mapper.sv
// Maps a buffer sample to a screen row: shift down, clamp to the visible range, invert.
module scope_row_mapper
  import scope_pkg::*;
(
  input  logic [DATA_W-1:0]  sample,
  output logic [COORD_W-1:0] row_c
);

  logic [COORD_W-1:0] scaled;
  logic [COORD_W-1:0] clamped;

  always_comb begin
    scaled  = COORD_W'(sample >> Y_SHIFT);
    clamped = (scaled > COORD_W'(V_ACTIVE - 1)) ? COORD_W'(V_ACTIVE - 1) : scaled;
    row_c   = COORD_W'(V_ACTIVE - 1) - clamped;
  end

endmodule

// File: rtl/scope_trace_renderer.sv
// Three-stage pixel pipeline: column fetch, sample return, row mapping and colouring.
// Optional background grid enabled by defining SCOPE_GRID_EN.
module scope_trace_renderer
  import scope_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic               pixelValid,
  output logic [COORD_W-1:0] screenX,
  input  logic [DATA_W-1:0]  screenData,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue,
  output logic               pixelOutValid
);

  logic [COORD_W-1:0] s1_x, s1_y, s2_x, s2_y;
  logic               s1_v, s2_v;
  logic [COORD_W-1:0] prev_y;
  logic               prev_v;

  logic [COORD_W-1:0] cur_y_c;
  logic [COORD_W-1:0] prev_sel_c, lo_c, hi_c;
  logic               lit_c;
  rgb_t               pix_rgb_c;

`ifdef SCOPE_GRID_EN
  localparam int unsigned GW = $clog2(GRID_STEP);
  logic [GW-1:0] gx_cnt, gy_cnt, gx_now_c, gy_now_c;
  logic          s1_grid, s2_grid;

  // Raster-order wrap counters stand in for coordinate mod GRID_STEP
  always_comb begin
    gx_now_c = (pixelX == '0 || gx_cnt == GW'(GRID_STEP - 1)) ? '0 : gx_cnt + GW'(1);
    gy_now_c = gy_cnt;
    if (pixelX == '0)
      gy_now_c = (pixelY == '0 || gy_cnt == GW'(GRID_STEP - 1)) ? '0 : gy_cnt + GW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gx_cnt  <= '0;
      gy_cnt  <= '0;
      s1_grid <= 1'b0;
      s2_grid <= 1'b0;
    end else begin
      if (pixelValid) begin
        gx_cnt <= gx_now_c;
        gy_cnt <= gy_now_c;
      end
      s1_grid <= (gx_now_c == '0) || (gy_now_c == '0);
      s2_grid <= s1_grid;
    end
  end
`endif

  // S1 issues the column, S2 waits for the registered buffer read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      screenX <= '0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_v    <= 1'b0;
      s2_x    <= '0;
      s2_y    <= '0;
      s2_v    <= 1'b0;
    end else begin
      screenX <= (pixelX > COORD_W'(H_ACTIVE - 1)) ? COORD_W'(H_ACTIVE - 1) : pixelX;
      s1_x    <= pixelX;
      s1_y    <= pixelY;
      s1_v    <= pixelValid;
      s2_x    <= s1_x;
      s2_y    <= s1_y;
      s2_v    <= s1_v;
    end
  end

  scope_row_mapper u_row_mapper (
    .sample (screenData),
    .row_c  (cur_y_c)
  );

  // Segment between previous and current column rows; a line start draws a single pixel
  always_comb begin
    prev_sel_c = (prev_v && s2_x != '0) ? prev_y : cur_y_c;
    lo_c       = (prev_sel_c < cur_y_c) ? prev_sel_c : cur_y_c;
    hi_c       = (prev_sel_c < cur_y_c) ? cur_y_c : prev_sel_c;
    lit_c      = s2_v && (s2_y >= lo_c) && (s2_y <= hi_c);
    pix_rgb_c  = BG_RGB;
`ifdef SCOPE_GRID_EN
    if (s2_grid) pix_rgb_c = GRID_RGB;
`endif
    if (lit_c) pix_rgb_c = TRACE_RGB;
    if (!s2_v) pix_rgb_c = '0;
  end

  // S3 output registers and trace history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      red           <= '0;
      green         <= '0;
      blue          <= '0;
      pixelOutValid <= 1'b0;
      prev_y        <= '0;
      prev_v        <= 1'b0;
    end else begin
      red           <= pix_rgb_c.r;
      green         <= pix_rgb_c.g;
      blue          <= pix_rgb_c.b;
      pixelOutValid <= s2_v;
      prev_v        <= s2_v;
      if (s2_v) prev_y <= cur_y_c;
    end
  end

endmodule

// File: tb/tb_scope_trace_renderer.sv
// Directed-vector bench for scope_trace_renderer with a registered sample-buffer model.
module tb_scope_trace_renderer;

  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] GREY  = 24'h404040;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] pixelX, pixelY;
  logic        pixelValid;
  logic [10:0] screenX;
  logic [13:0] screenData;
  logic [7:0]  red, green, blue;
  logic        pixelOutValid;

  logic [13:0] mem [0:799];

  int n_vec = 0;
  int n_bad = 0;

  // Expectations for the last three driven pixels; index 2 is due at the output
  bit          h_chk [3];
  logic [23:0] h_rgb [3];
  bit          h_v   [3];
  string       h_tag [3];

  always #5 clock = ~clock;

  always @(posedge clock) screenData <= mem[screenX];

  scope_trace_renderer dut (
    .clock         (clock),
    .reset         (reset),
    .pixelX        (pixelX),
    .pixelY        (pixelY),
    .pixelValid    (pixelValid),
    .screenX       (screenX),
    .screenData    (screenData),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .pixelOutValid (pixelOutValid)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int x, input int y, input bit v, input bit c,
                      input logic [23:0] er, input string tag);
    pixelX     = 11'(x);
    pixelY     = 11'(y);
    pixelValid = v;
    @(posedge clock);
    #1;
    for (int i = 2; i > 0; i--) begin
      h_chk[i] = h_chk[i-1];
      h_rgb[i] = h_rgb[i-1];
      h_v[i]   = h_v[i-1];
      h_tag[i] = h_tag[i-1];
    end
    h_chk[0] = c;
    h_rgb[0] = er;
    h_v[0]   = v;
    h_tag[0] = tag;
    if (h_chk[2]) begin
      check({h_tag[2], "_rgb"}, int'({red, green, blue}), int'(h_rgb[2]));
      check({h_tag[2], "_vld"}, int'(pixelOutValid), int'(h_v[2]));
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b1, BLACK, "blank");
  endtask

  task automatic fill(input logic [13:0] val);
    for (int i = 0; i < 800; i++) mem[i] = val;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      h_chk[i] = 1'b1;
      h_rgb[i] = BLACK;
      h_v[i]   = 1'b0;
      h_tag[i] = "post_reset";
    end
    fill(14'd16383);
    reset      = 1'b0;
    pixelX     = 11'd5;
    pixelY     = 11'd0;
    pixelValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("reset_rgb", int'({red, green, blue}), 0);
      check("reset_vld", int'(pixelOutValid), 0);
      check("reset_sx", int'(screenX), 0);
    end
    reset = 1'b1;

    // Full-scale sample clamps to row 0
    for (int x = 0; x < 4; x++) step(x, 0, 1'b1, 1'b1, GREEN, "max_row0");
    blank(3);
    for (int x = 0; x < 4; x++) step(x, 1, 1'b1, 1'b1, BLACK, "max_row1");
    blank(3);

    // Zero sample maps to the bottom row
    fill(14'd0);
    blank(2);
    for (int x = 0; x < 3; x++) step(x, 479, 1'b1, 1'b1, GREEN, "zero_row479");
    blank(3);
    for (int x = 0; x < 3; x++) step(x, 478, 1'b1, 1'b1, BLACK, "zero_row478");
    blank(3);

    // Column beyond the visible width reads the last column
    step(900, 479, 1'b1, 1'b1, GREEN, "clamp_x");
    check("clamp_sx", int'(screenX), 799);
    step(900, 600, 1'b1, 1'b1, BLACK, "row_oob");
    blank(3);

    // Steep edge between columns 10 and 11, and line-start isolation
    mem[10] = 14'd3200;
    mem[11] = 14'd9600;
    mem[5]  = 14'd16383;
    mem[0]  = 14'd5728;
    blank(2);
    step(10, 179, 1'b1, 1'b1, BLACK, "seg10_y179");
    step(11, 179, 1'b1, 1'b1, GREEN, "seg11_y179");
    blank(2);
    step(10, 379, 1'b1, 1'b1, GREEN, "seg10_y379");
    step(11, 379, 1'b1, 1'b1, GREEN, "seg11_y379");
    blank(2);
    step(10, 178, 1'b1, 1'b1, BLACK, "seg10_y178");
    step(11, 178, 1'b1, 1'b1, BLACK, "seg11_y178");
    blank(2);
    step(10, 380, 1'b1, 1'b1, BLACK, "seg10_y380");
    step(11, 380, 1'b1, 1'b1, BLACK, "seg11_y380");
    blank(2);
    step(10, 250, 1'b1, 1'b1, BLACK, "seg10_y250");
    step(11, 250, 1'b1, 1'b1, GREEN, "seg11_y250");
    blank(2);
    step(5, 150, 1'b1, 1'b1, BLACK, "pre_x5_y150");
    step(0, 150, 1'b1, 1'b1, BLACK, "start_y150");
    blank(2);
    step(5, 300, 1'b1, 1'b1, BLACK, "pre_x5_y300");
    step(0, 300, 1'b1, 1'b1, GREEN, "start_y300");
    blank(3);

    // Flat trace at row 240 over the background
    fill(14'd7648);
    blank(2);
`ifdef SCOPE_GRID_EN
    for (int y = 0; y <= 240; y++) begin
      for (int x = 0; x < 60; x++) begin
        if (x == 50 && y == 100)      step(x, y, 1'b1, 1'b1, GREY,  "grid_50_100");
        else if (x == 50 && y == 240) step(x, y, 1'b1, 1'b1, GREEN, "grid_50_240");
        else if (x == 51 && y == 101) step(x, y, 1'b1, 1'b1, BLACK, "grid_51_101");
        else if (x == 0 && y == 0)    step(x, y, 1'b1, 1'b1, GREY,  "grid_0_0");
        else                          step(x, y, 1'b1, 1'b0, BLACK, "");
      end
      blank(2);
    end
`else
    step(50, 100, 1'b1, 1'b1, BLACK, "nogrid_50_100");
    step(50, 240, 1'b1, 1'b1, GREEN, "nogrid_50_240");
    step(51, 101, 1'b1, 1'b1, BLACK, "nogrid_51_101");
`endif
    blank(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
